// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: rotating-priority arbiter that holds each grant for a burst of up to MAX_BURST beats.
// Latency: request to registered grant in 1 cycle; handover between holders is zero-bubble.
// Backpressure: none; a burst ends on request drop or quota. WRR_BURST_ARBITER_LOCK_EN lets lock extend a burst.
module wrr_burst_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 8,
    parameter int ID_W      = $clog2(N),
    parameter int CNT_W     = $clog2(MAX_BURST)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     request,
    input  logic [N-1:0]     lock,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             quota_expire
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  ptr_after;
    logic [ID_W-1:0]  search_start;
    logic [ID_W-1:0]  search_idx;
    logic [ID_W-1:0]  id_nxt;
    logic [ID_W:0]    idx_sum;
    logic             search_found;
    logic [2*N-1:0]   req_rot;
    logic [N-1:0]     grant_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             qe_nxt;
    logic             hold_req;
    logic             at_quota;
    logic             lock_hold;

    assign hold_req  = |(request & grant);
    assign at_quota  = (beat_cnt == LAST_BEAT);
    assign ptr_after = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

    // While busy the search always starts just past the holder, so the holder is considered last.
    assign search_start = (state == BUSY) ? ptr_after : ptr;
    assign req_rot      = {request, request} >> search_start;

`ifdef WRR_BURST_ARBITER_LOCK_EN
    assign lock_hold = |(lock & grant);
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign lock_hold   = 1'b0;
`endif

    always_comb begin
        search_found = 1'b0;
        idx_sum      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                search_found = 1'b1;
                idx_sum      = {1'b0, search_start} + (ID_W + 1)'(i);
            end
        end
        search_idx = (idx_sum >= (ID_W + 1)'(N)) ? ID_W'(idx_sum - (ID_W + 1)'(N))
                                                 : ID_W'(idx_sum);
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        id_nxt    = grant_id;
        cnt_nxt   = beat_cnt;
        qe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (search_found) begin
                    state_nxt             = BUSY;
                    grant_nxt             = '0;
                    grant_nxt[search_idx] = 1'b1;
                    id_nxt                = search_idx;
                    cnt_nxt               = '0;
                end
            end
            BUSY: begin
                if (hold_req && !at_quota) begin
                    cnt_nxt = beat_cnt + CNT_W'(1);
                end else if (hold_req && lock_hold) begin
                    cnt_nxt = beat_cnt;
                end else begin
                    // Burst ends: release (request dropped) or quota; release wins if both.
                    ptr_nxt = ptr_after;
                    qe_nxt  = hold_req;
                    cnt_nxt = '0;
                    if (search_found) begin
                        grant_nxt             = '0;
                        grant_nxt[search_idx] = 1'b1;
                        id_nxt                = search_idx;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        id_nxt    = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                id_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            grant        <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            beat_cnt     <= '0;
            quota_expire <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            grant        <= grant_nxt;
            grant_valid  <= |grant_nxt;
            grant_id     <= id_nxt;
            beat_cnt     <= cnt_nxt;
            quota_expire <= qe_nxt;
        end
    end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter (N=4, MAX_BURST=4) with hand-computed expectations.
module tb_wrr_burst_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] lock;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [1:0] beat_cnt;
    logic       quota_expire;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wrr_burst_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .request      (request),
        .lock         (lock),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .beat_cnt     (beat_cnt),
        .quota_expire (quota_expire)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input int id,
                              input int cnt, input logic qe);
        chk({tag, ".grant"},        32'(grant),        32'(g));
        chk({tag, ".grant_valid"},  32'(grant_valid),  32'(|g));
        chk({tag, ".grant_id"},     32'(grant_id),     32'(id));
        chk({tag, ".beat_cnt"},     32'(beat_cnt),     32'(cnt));
        chk({tag, ".quota_expire"}, 32'(quota_expire), 32'(qe));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        request = 4'b0000;
        lock    = 4'b0000;
        tick();
        tick();
        expect_out("reset", 4'b0000, 0, 0, 1'b0);
        reset = 1'b0;

        // First grant searches from index 0; quota hands over to the next requester.
        request = 4'b0110;
        tick();
        expect_out("t1.first", 4'b0010, 1, 0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_out("t1.hold", 4'b0010, 1, k, 1'b0);
        end
        tick();
        expect_out("t1.quota", 4'b0100, 2, 0, 1'b1);
        tick();
        expect_out("t1.next", 4'b0100, 2, 1, 1'b0);

        // Release with others pending: zero-bubble handover.
        request = 4'b1001;
        tick();
        expect_out("t2.handover", 4'b1000, 3, 0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_out("t2.hold", 4'b1000, 3, k, 1'b0);
        end
        tick();
        expect_out("t2.quota", 4'b0001, 0, 0, 1'b1);

        // Lone requester is re-granted at each quota.
        request = 4'b0001;
`ifndef WRR_BURST_ARBITER_LOCK_EN
        lock = 4'b1111;
`endif
        for (int k = 1; k <= 10; k++) begin
            tick();
            expect_out("t3.solo", 4'b0001, 0, k % 4, (k % 4) == 0);
        end
        lock = 4'b0000;

        // Async reset at beat_cnt=2 clears outputs before the next edge.
        reset = 1'b1;
        #1;
        expect_out("t5.async_rst", 4'b0000, 0, 0, 1'b0);
        tick();
        reset   = 1'b0;
        request = 4'b0100;
        tick();
        expect_out("t5.after_rst", 4'b0100, 2, 0, 1'b0);

        // All requesting from reset: round-robin 0,1,2,3,0 with 4 beats each.
        reset   = 1'b1;
        request = 4'b0000;
        tick();
        reset   = 1'b0;
        request = 4'b1111;
        tick();
        expect_out("t4.first", 4'b0001, 0, 0, 1'b0);
        for (int k = 1; k < 20; k++) begin
            int h;
            h = (k / 4) % 4;
            tick();
            expect_out("t4.rr", 4'(1 << h), h, k % 4, (k % 4) == 0);
        end

        // Holder 0 at its last beat drops request: treated as release, no quota pulse.
        request = 4'b1110;
        tick();
        expect_out("t6.rel_at_quota", 4'b0010, 1, 0, 1'b0);
        request = 4'b1011;
        tick();
        expect_out("t6.nonholder_chg", 4'b0010, 1, 1, 1'b0);

        // Release with no other request goes idle; ptr moves to 2.
        request = 4'b0000;
        tick();
        expect_out("t7.idle", 4'b0000, 0, 0, 1'b0);
        tick();
        expect_out("t7.idle_stay", 4'b0000, 0, 0, 1'b0);
        request = 4'b0011;
        tick();
        expect_out("t7.ptr_wrap", 4'b0001, 0, 0, 1'b0);

`ifdef WRR_BURST_ARBITER_LOCK_EN
        reset   = 1'b1;
        request = 4'b0000;
        lock    = 4'b0000;
        tick();
        reset   = 1'b0;
        request = 4'b0011;
        lock    = 4'b0010;
        tick();
        expect_out("lk.first", 4'b0001, 0, 0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_out("lk.hold0", 4'b0001, 0, k, 1'b0);
        end
        tick();
        expect_out("lk.quota0", 4'b0010, 1, 0, 1'b1);
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_out("lk.hold1", 4'b0010, 1, k, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("lk.saturate", 4'b0010, 1, 3, 1'b0);
        end
        lock = 4'b0000;
        tick();
        expect_out("lk.unlock", 4'b0001, 0, 0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
